// File: rtl/game_pkg.sv
// Shared game-sequencing types: frame FSM state encoding and the period clamp
// used by the tick generator and the object-update FSMs.
package game_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2
    } game_state_e;

    // A frame shorter than the phase set would swallow strobes, so raise it.
    function automatic logic [31:0] clampPeriod(input logic [31:0] p, input logic [31:0] minP);
        return (p < minP) ? minP : p;
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Frame-tick generator: programmable frame period, pause/step, and NUM_PHASES
// one-cycle phase strobes at the start of every frame.
module game_tick_gen
    import game_pkg::*;
#(
    parameter int unsigned WIDTH          = 20,
    parameter int unsigned NUM_PHASES     = 3,
    parameter int unsigned DEFAULT_PERIOD = 2**WIDTH - 1,
    parameter int unsigned FCNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  step_i,
    input  logic [WIDTH-1:0]      period_i,
    output logic [NUM_PHASES-1:0] tick_o,
    output logic                  frame_o,
    output logic [FCNT_WIDTH-1:0] frame_cnt_o,
    output logic                  running_o,
    output logic [1:0]            dbgState
);

    localparam logic [WIDTH-1:0] RESET_PERIOD =
        WIDTH'(clampPeriod(32'(DEFAULT_PERIOD), 32'(NUM_PHASES)));

    game_state_e state, stateNext;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      periodQ;
    logic [WIDTH-1:0]      periodNext;
    logic [FCNT_WIDTH-1:0] frameCnt;
    logic [NUM_PHASES-1:0] phaseHit;
    logic                  active;
    logic                  wrap;

    assign active     = (state != PAUSE);
    assign wrap       = (cnt == periodQ - WIDTH'(1));
    assign periodNext = WIDTH'(clampPeriod(32'(period_i), 32'(NUM_PHASES)));
    assign dbgState   = state;

    always_comb begin
        stateNext = state;
        case (state)
            PAUSE: begin
                if (enable_i) stateNext = RUN;
                else if (step_i) stateNext = STEP;
            end
            RUN, STEP: begin
                // Pause only lands on a frame boundary, never mid-frame.
                if (wrap) stateNext = enable_i ? RUN : PAUSE;
            end
            default: stateNext = PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PAUSE;
            cnt      <= '0;
            periodQ  <= RESET_PERIOD;
            frameCnt <= '0;
        end else begin
            state <= stateNext;
            if (!active) begin
                cnt <= '0;
            end else if (wrap) begin
                cnt      <= '0;
                periodQ  <= periodNext;
                frameCnt <= frameCnt + FCNT_WIDTH'(1);
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_PHASES; k++) begin : gPhase
        assign phaseHit[k] = active && (cnt == WIDTH'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_o    <= '0;
            frame_o   <= 1'b0;
            running_o <= 1'b0;
        end else begin
            tick_o    <= phaseHit;
            frame_o   <= active && wrap;
            running_o <= (stateNext != PAUSE);
        end
    end

    assign frame_cnt_o = frameCnt;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen: table-driven first frame, then frame-level
// sequences for period changes, clamping, pause/step, reset and count wrap.
module tb_game_tick_gen;

    localparam int FW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          step_i;
    logic [7:0]    period_i;
    logic [2:0]    tick_o;
    logic          frame_o;
    logic [FW-1:0] frame_cnt_o;
    logic          running_o;
    logic [1:0]    dbgState;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] expFcnt = '0;

    typedef struct {
        logic          en;
        logic          st;
        logic [7:0]    per;
        logic [2:0]    tick;
        logic          frame;
        logic          run;
        logic [FW-1:0] fcnt;
    } vec_t;

    vec_t vecs[11];

    game_tick_gen #(
        .WIDTH(8), .NUM_PHASES(3), .DEFAULT_PERIOD(10), .FCNT_WIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .step_i(step_i),
        .period_i(period_i), .tick_o(tick_o), .frame_o(frame_o),
        .frame_cnt_o(frame_cnt_o), .running_o(running_o), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One frame of len cycles; inputs optionally change after cycle chgAt.
    task automatic runFrame(input int len, input int chgAt, input logic [7:0] newPer,
                            input logic newEn, input string nm);
        logic enNow;
        for (int c = 0; c < len; c++) begin
            enNow = enable_i;
            @(negedge clk);
            if (c == len - 1) expFcnt++;
            chk({nm, "_tick"}, 32'(tick_o), (c < 3) ? (32'd1 << c) : 32'd0);
            chk({nm, "_frame"}, 32'(frame_o), 32'(c == len - 1));
            chk({nm, "_run"}, 32'(running_o), (c == len - 1) ? 32'(enNow) : 32'd1);
            chk({nm, "_fcnt"}, 32'(frame_cnt_o), 32'(expFcnt));
            if (c == chgAt) begin
                period_i = newPer;
                enable_i = newEn;
            end
        end
    endtask

    task automatic pausedCycles(input int n, input string nm);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk({nm, "_tick"}, 32'(tick_o), 32'd0);
            chk({nm, "_frame"}, 32'(frame_o), 32'd0);
            chk({nm, "_run"}, 32'(running_o), 32'd0);
            chk({nm, "_state"}, 32'(dbgState), 32'd0);
            chk({nm, "_fcnt"}, 32'(frame_cnt_o), 32'(expFcnt));
        end
    endtask

    // First cycle after leaving PAUSE: state changed, no strobe yet.
    task automatic startCycle(input logic [1:0] expState, input string nm);
        @(negedge clk);
        chk({nm, "_tick"}, 32'(tick_o), 32'd0);
        chk({nm, "_run"}, 32'(running_o), 32'd1);
        chk({nm, "_state"}, 32'(dbgState), 32'(expState));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'd10, 3'b001, 1'b0, 1'b1, 12'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'd10, 3'b010, 1'b0, 1'b1, 12'd0};
        vecs[3]  = '{1'b1, 1'b0, 8'd10, 3'b100, 1'b0, 1'b1, 12'd0};
        vecs[4]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[5]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[8]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[9]  = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b0, 1'b1, 12'd0};
        vecs[10] = '{1'b1, 1'b0, 8'd10, 3'b000, 1'b1, 1'b1, 12'd1};

        rst_n    = 1'b0;
        enable_i = 1'b1;
        step_i   = 1'b0;
        period_i = 8'd10;
        repeat (2) @(negedge clk);
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_run", 32'(running_o), 32'd0);
        chk("rst_state", 32'(dbgState), 32'd0);
        rst_n = 1'b1;

        // Test 1: first frame from reset, table-driven.
        for (int i = 0; i < 11; i++) begin
            enable_i = vecs[i].en;
            step_i   = vecs[i].st;
            period_i = vecs[i].per;
            @(negedge clk);
            chk($sformatf("vec%0d_tick", i), 32'(tick_o), 32'(vecs[i].tick));
            chk($sformatf("vec%0d_frame", i), 32'(frame_o), 32'(vecs[i].frame));
            chk($sformatf("vec%0d_run", i), 32'(running_o), 32'(vecs[i].run));
            chk($sformatf("vec%0d_fcnt", i), 32'(frame_cnt_o), 32'(vecs[i].fcnt));
        end
        expFcnt = 12'd1;
        for (int f = 0; f < 4; f++) runFrame(10, -1, 8'd10, 1'b1, "run10");
        chk("fcnt_after_50", 32'(frame_cnt_o), 32'd5);

        // Test 2: period change mid-frame takes effect at the next frame.
        runFrame(10, 2, 8'd4, 1'b1, "per_chg");
        runFrame(4, -1, 8'd4, 1'b1, "per4a");
        runFrame(4, 1, 8'd1, 1'b1, "per4b");

        // Test 3: periods 1 and 0 clamp to the phase count.
        runFrame(3, 0, 8'd0, 1'b1, "clamp1");
        runFrame(3, -1, 8'd0, 1'b1, "clamp0a");
        runFrame(3, 0, 8'd10, 1'b1, "clamp0b");

        // Test 4: enable dropped at frame cycle 5, then a single step.
        runFrame(10, 5, 8'd10, 1'b0, "drop_en");
        pausedCycles(4, "paused");
        step_i = 1'b1;
        startCycle(2'd2, "step_start");
        step_i = 1'b0;
        runFrame(10, -1, 8'd10, 1'b0, "step_frame");
        pausedCycles(3, "paused2");

        // Test 5: enable beats step in PAUSE.
        step_i   = 1'b1;
        enable_i = 1'b1;
        startCycle(2'd1, "prio_start");
        step_i = 1'b0;
        runFrame(10, -1, 8'd10, 1'b1, "prio_a");
        runFrame(10, -1, 8'd10, 1'b1, "prio_b");

        // Test 6: asynchronous reset while tick_o=010.
        @(negedge clk);
        chk("pre_rst_tick0", 32'(tick_o), 32'b001);
        @(negedge clk);
        chk("pre_rst_tick1", 32'(tick_o), 32'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", 32'(tick_o), 32'd0);
        chk("arst_frame", 32'(frame_o), 32'd0);
        chk("arst_fcnt", 32'(frame_cnt_o), 32'd0);
        chk("arst_run", 32'(running_o), 32'd0);
        chk("arst_state", 32'(dbgState), 32'd0);
        expFcnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Test 7: frame count wraps modulo 2**FW.
        startCycle(2'd1, "rerun_start");
        runFrame(10, 0, 8'd3, 1'b1, "rerun10");
        for (int f = 1; f < (1 << FW); f++) runFrame(3, -1, 8'd3, 1'b1, "wrap");
        chk("fcnt_wrap", 32'(frame_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
